regs_wport_arb: RTL and testbench

- Write-port arbiter for the 32x32 integer register file.
- Shares the single file write port between three requesters:
  - EX writeback: no handshake, highest priority.
  - Multi-cycle divider writeback: req/ack.
  - JTAG debug register write: req/ack.
- A starvation counter forces a one-cycle pipeline hold so side requesters always complete.
- Sits between EX, the divider, the JTAG DM and the register file's we/waddr/wdata inputs.

---
 rtl/regs_wport_if.sv | 38 +++
 rtl/regs_wport_arb.sv | 158 +++++++++++++++
 tb/tb_regs_wport_arb.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/regs_wport_if.sv
// Write-port bundle between the EX, divider and JTAG requesters and the
// register-file write arbiter.
interface regs_wport_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              ex_we_i;
  logic [ADDR_W-1:0] ex_waddr_i;
  logic [DATA_W-1:0] ex_wdata_i;
  logic              div_req_i;
  logic [ADDR_W-1:0] div_waddr_i;
  logic [DATA_W-1:0] div_wdata_i;
  logic              div_ack_o;
  logic              jtag_req_i;
  logic [ADDR_W-1:0] jtag_addr_i;
  logic [DATA_W-1:0] jtag_data_i;
  logic              jtag_ack_o;
  logic              hold_o;
  logic              we_o;
  logic [ADDR_W-1:0] waddr_o;
  logic [DATA_W-1:0] wdata_o;

  modport master (
    output ex_we_i, ex_waddr_i, ex_wdata_i,
    output div_req_i, div_waddr_i, div_wdata_i,
    output jtag_req_i, jtag_addr_i, jtag_data_i,
    input  div_ack_o, jtag_ack_o, hold_o,
    input  we_o, waddr_o, wdata_o
  );

  modport slave (
    input  ex_we_i, ex_waddr_i, ex_wdata_i,
    input  div_req_i, div_waddr_i, div_wdata_i,
    input  jtag_req_i, jtag_addr_i, jtag_data_i,
    output div_ack_o, jtag_ack_o, hold_o,
    output we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/regs_wport_arb.sv
// Register-file write-port arbiter: EX > round-robin(divider, JTAG),
// with a starvation-forced one-cycle hold. Optional: REGS_ARB_STATS_EN.
module regs_wport_arb #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef REGS_ARB_STATS_EN
  input  logic        stats_clr_i,
  output logic [15:0] hold_cnt_o,
`endif
  regs_wport_if.slave bus
);

  typedef enum logic {S_RUN, S_HOLD} state_t;

  localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ptr;
  logic              w_ptr_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              r_div_busy;
  logic              r_jtag_busy;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_div_el;
  logic              w_jtag_el;
  logic              w_pick_div;
  logic              w_pick_jtag;
  logic              w_g_ex;
  logic              w_g_div;
  logic              w_g_jtag;
  logic              w_g_any;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;

  // Busy bit equals the ack pulse: blocks re-grant in the ack cycle.
  assign w_div_el    = bus.div_req_i & ~r_div_busy;
  assign w_jtag_el   = bus.jtag_req_i & ~r_jtag_busy;
  // r_ptr: 0 = divider preferred, 1 = JTAG preferred.
  assign w_pick_div  = w_div_el & (~w_jtag_el | ~r_ptr);
  assign w_pick_jtag = w_jtag_el & (~w_div_el | r_ptr);

  // Next-state, grant selection and starvation counter update.
  always_comb begin
    w_state_nxt = S_RUN;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_g_ex      = 1'b0;
    w_g_div     = 1'b0;
    w_g_jtag    = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (bus.ex_we_i) begin
          w_g_ex = 1'b1;
        end else begin
          w_g_div  = w_pick_div;
          w_g_jtag = w_pick_jtag;
        end
        if (w_g_div || w_g_jtag || !(w_div_el || w_jtag_el))
          w_cnt_nxt = 4'd0;
        else if (r_cnt != 4'd15)
          w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == LP_MAX)
          w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        w_g_div   = w_pick_div;
        w_g_jtag  = w_pick_jtag;
        w_cnt_nxt = 4'd0;
      end
      default: w_state_nxt = S_RUN;
    endcase
    if (w_g_div)  w_ptr_nxt = 1'b1;
    if (w_g_jtag) w_ptr_nxt = 1'b0;
  end

  assign w_g_any = w_g_ex | w_g_div | w_g_jtag;

  // Write payload of whichever requester won this cycle.
  always_comb begin
    w_addr = bus.ex_waddr_i;
    w_data = bus.ex_wdata_i;
    unique case (1'b1)
      w_g_div: begin
        w_addr = bus.div_waddr_i;
        w_data = bus.div_wdata_i;
      end
      w_g_jtag: begin
        w_addr = bus.jtag_addr_i;
        w_data = bus.jtag_data_i;
      end
      default: ;
    endcase
  end

  // Control state: FSM, pointer, counter, busy/ack bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_ptr       <= 1'b0;
      r_cnt       <= 4'd0;
      r_div_busy  <= 1'b0;
      r_jtag_busy <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_div_busy  <= w_g_div;
      r_jtag_busy <= w_g_jtag;
    end
  end

  // Registered write port; x0 grants update addr/data but never write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= w_g_any && (w_addr != '0);
      if (w_g_any) begin
        r_waddr <= w_addr;
        r_wdata <= w_data;
      end
    end
  end

`ifdef REGS_ARB_STATS_EN
  logic [15:0] r_hold_cnt;

  // Saturating HOLD-cycle counter; clear wins over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_hold_cnt <= 16'd0;
    else if (stats_clr_i)
      r_hold_cnt <= 16'd0;
    else if (r_state == S_HOLD && r_hold_cnt != 16'hFFFF)
      r_hold_cnt <= r_hold_cnt + 16'd1;
  end

  assign hold_cnt_o = r_hold_cnt;
`endif

  assign bus.div_ack_o  = r_div_busy;
  assign bus.jtag_ack_o = r_jtag_busy;
  assign bus.hold_o     = (r_state == S_HOLD);
  assign bus.we_o       = r_we;
  assign bus.waddr_o    = r_waddr;
  assign bus.wdata_o    = r_wdata;

endmodule

// File: tb/tb_regs_wport_arb.sv
// Directed bench for regs_wport_arb with a per-cycle expected-output
// scoreboard.
module tb_regs_wport_arb;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        dack;
    logic        jack;
    logic        hold;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  regs_wport_if #(.ADDR_W(5), .DATA_W(32)) bus ();

`ifdef REGS_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] hold_cnt;
`endif

  regs_wport_arb #(
    .ADDR_W(5),
    .DATA_W(32),
    .STARVE_MAX(4)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef REGS_ARB_STATS_EN
    .stats_clr_i(stats_clr),
    .hold_cnt_o(hold_cnt),
`endif
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(logic we, logic [4:0] a, logic [31:0] d,
                              logic da, logic ja, logic h);
    exp_t e;
    e.we = we; e.waddr = a; e.wdata = d;
    e.dack = da; e.jack = ja; e.hold = h;
    return e;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, ".we"},    32'(bus.we_o),       32'(e.we));
      chk({tag, ".waddr"}, 32'(bus.waddr_o),    32'(e.waddr));
      chk({tag, ".wdata"}, bus.wdata_o,          e.wdata);
      chk({tag, ".dack"},  32'(bus.div_ack_o),  32'(e.dack));
      chk({tag, ".jack"},  32'(bus.jtag_ack_o), 32'(e.jack));
      chk({tag, ".hold"},  32'(bus.hold_o),     32'(e.hold));
    end
  endtask

  task automatic now(string tag, exp_t e);
    sb.push_back(e);
    check_out(tag);
  endtask

  task automatic cyc(string tag, exp_t e);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    #2;
    now(tag, mk(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.ex_we_i = 0; bus.ex_waddr_i = 0; bus.ex_wdata_i = 0;
    bus.div_req_i = 0; bus.div_waddr_i = 0; bus.div_wdata_i = 0;
    bus.jtag_req_i = 0; bus.jtag_addr_i = 0; bus.jtag_data_i = 0;
`ifdef REGS_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    do_reset("reset");

    // EX only
    bus.ex_we_i = 1; bus.ex_waddr_i = 5; bus.ex_wdata_i = 32'hDEADBEEF;
    cyc("ex_only", mk(1, 5, 32'hDEADBEEF, 0, 0, 0));
    bus.ex_we_i = 0;
    cyc("idle_hold", mk(0, 5, 32'hDEADBEEF, 0, 0, 0));

    // Divider alone
    bus.div_req_i = 1; bus.div_waddr_i = 7; bus.div_wdata_i = 32'h12345678;
    cyc("div_grant", mk(1, 7, 32'h12345678, 1, 0, 0));
    cyc("div_busy", mk(0, 7, 32'h12345678, 0, 0, 0));
    bus.div_req_i = 0;
    cyc("div_done", mk(0, 7, 32'h12345678, 0, 0, 0));

    // Contention from reset pointer
    do_reset("reset2");
    bus.div_req_i = 1; bus.div_waddr_i = 9; bus.div_wdata_i = 32'h11111111;
    bus.jtag_req_i = 1; bus.jtag_addr_i = 10; bus.jtag_data_i = 32'h22222222;
    cyc("cont_div", mk(1, 9, 32'h11111111, 1, 0, 0));
    bus.div_req_i = 0;
    cyc("cont_jtag", mk(1, 10, 32'h22222222, 0, 1, 0));
    bus.jtag_req_i = 0;
    cyc("cont_idle", mk(0, 10, 32'h22222222, 0, 0, 0));

    // Starvation forces a one-cycle hold
    bus.jtag_req_i = 1; bus.jtag_addr_i = 3; bus.jtag_data_i = 32'hA5A5A5A5;
    bus.ex_we_i = 1; bus.ex_waddr_i = 1;
    for (int i = 0; i < 5; i++) begin
      bus.ex_wdata_i = 32'h100 + 32'(i);
      cyc($sformatf("starve%0d", i),
          mk(1, 1, 32'h100 + 32'(i), 0, 0, i == 4));
    end
    bus.ex_wdata_i = 32'h105;
    cyc("hold_jtag", mk(1, 3, 32'hA5A5A5A5, 0, 1, 0));
    bus.jtag_req_i = 0;
    cyc("ex_resume", mk(1, 1, 32'h105, 0, 0, 0));
    bus.ex_we_i = 0;

    // JTAG write to x0
    bus.jtag_req_i = 1; bus.jtag_addr_i = 0; bus.jtag_data_i = 32'hCAFEF00D;
    cyc("x0_jtag", mk(0, 0, 32'hCAFEF00D, 0, 1, 0));
    bus.jtag_req_i = 0;

    // Reset while the divider is pending
    bus.ex_we_i = 1; bus.ex_waddr_i = 4; bus.ex_wdata_i = 32'h44;
    bus.div_req_i = 1; bus.div_waddr_i = 12; bus.div_wdata_i = 32'h777;
    cyc("ex_over_div", mk(1, 4, 32'h44, 0, 0, 0));
    bus.ex_we_i = 0;
    rst = 1'b1;
    #1;
    now("rst_async", mk(0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    now("rst_held", mk(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    now("rst_release", mk(0, 0, 0, 0, 0, 0));
    cyc("div_regrant", mk(1, 12, 32'h777, 1, 0, 0));
    bus.div_req_i = 0;
    cyc("div_regrant_done", mk(0, 12, 32'h777, 0, 0, 0));

`ifdef REGS_ARB_STATS_EN
    do_reset("reset3");
    bus.ex_waddr_i = 2; bus.ex_wdata_i = 32'h2;
    bus.jtag_addr_i = 6; bus.jtag_data_i = 32'h6;
    for (int h = 0; h < 3; h++) begin
      bus.ex_we_i = 1; bus.jtag_req_i = 1;
      repeat (6) @(posedge clk);
      #1;
      chk("stats_jack", 32'(bus.jtag_ack_o), 32'd1);
      bus.jtag_req_i = 0;
      @(posedge clk);
      #1;
    end
    bus.ex_we_i = 0;
    chk("hold_cnt3", 32'(hold_cnt), 32'd3);
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    chk("hold_cnt_clr", 32'(hold_cnt), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
